// File: rtl/vram_arbiter.sv
// Arbiter for a shared single-port video RAM: the display reader has strict
// priority over the CPU, and a wait counter flags CPU starvation.
module vram_arbiter #(
    parameter int ADDR_WIDTH   = 16,
    parameter int STARVE_LIMIT = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  vga_req,
    input  logic [ADDR_WIDTH-1:0] vga_addr,
    output logic [15:0]           vga_data,
    output logic                  vga_valid,
    input  logic                  cpu_req,
    input  logic                  cpu_we,
    input  logic [ADDR_WIDTH-1:0] cpu_addr,
    input  logic [15:0]           cpu_wdata,
    output logic [15:0]           cpu_rdata,
    output logic                  cpu_ack,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [15:0]           mem_wdata,
    output logic                  mem_we,
    input  logic [15:0]           mem_rdata,
    output logic                  cpu_starve
);
    localparam int CW = $clog2(STARVE_LIMIT + 1);

    typedef enum logic [2:0] {
        IDLE, VGA_RD, CPU_RD, CPU_WR, CAPTURE_V, CAPTURE_C
    } state_t;

    state_t        state;
    logic [CW-1:0] wait_cnt;
    logic          done;
    logic          cpu_grant;

    // The completion cycle is spent in IDLE without granting, so the
    // finishing requester has time to drop its request.
    assign done      = vga_valid | cpu_ack;
    assign cpu_grant = (state == IDLE) && !done && !vga_req && cpu_req;
    assign cpu_starve = (wait_cnt == CW'(STARVE_LIMIT));

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_we    <= 1'b0;
            vga_data  <= '0;
            vga_valid <= 1'b0;
            cpu_rdata <= '0;
            cpu_ack   <= 1'b0;
            wait_cnt  <= '0;
        end else begin
            vga_valid <= 1'b0;
            cpu_ack   <= 1'b0;
            mem_we    <= 1'b0;
            case (state)
                IDLE: begin
                    if (!done) begin
                        if (vga_req) begin
                            mem_addr <= vga_addr;
                            state    <= VGA_RD;
                        end else if (cpu_req) begin
                            mem_addr  <= cpu_addr;
                            mem_wdata <= cpu_wdata;
                            mem_we    <= cpu_we;
                            state     <= cpu_we ? CPU_WR : CPU_RD;
                        end
                    end
                end
                VGA_RD: state <= CAPTURE_V;
                CPU_RD: state <= CAPTURE_C;
                CAPTURE_V: begin
                    vga_data  <= mem_rdata;
                    vga_valid <= 1'b1;
                    state     <= IDLE;
                end
                CAPTURE_C: begin
                    cpu_rdata <= mem_rdata;
                    cpu_ack   <= 1'b1;
                    state     <= IDLE;
                end
                CPU_WR: begin
                    cpu_ack <= 1'b1;
                    state   <= IDLE;
                end
                default: state <= IDLE;
            endcase

            if (!cpu_req || cpu_grant)
                wait_cnt <= '0;
            else if (wait_cnt != CW'(STARVE_LIMIT))
                wait_cnt <= wait_cnt + CW'(1);
        end
    end
endmodule

// File: tb/tb_vram_arbiter.sv
// Directed bench for vram_arbiter with a synchronous-read RAM model.
module tb_vram_arbiter;
    logic        clk = 1'b0;
    logic        reset;
    logic        vga_req;
    logic [15:0] vga_addr;
    logic [15:0] vga_data;
    logic        vga_valid;
    logic        cpu_req;
    logic        cpu_we;
    logic [15:0] cpu_addr;
    logic [15:0] cpu_wdata;
    logic [15:0] cpu_rdata;
    logic        cpu_ack;
    logic [15:0] mem_addr;
    logic [15:0] mem_wdata;
    logic        mem_we;
    logic [15:0] mem_rdata;
    logic        cpu_starve;

    int checks = 0;
    int errors = 0;

    logic [15:0] ram [0:65535];

    always #10 clk = ~clk;

    vram_arbiter #(.ADDR_WIDTH(16), .STARVE_LIMIT(8)) dut (
        .clk(clk), .reset(reset),
        .vga_req(vga_req), .vga_addr(vga_addr), .vga_data(vga_data), .vga_valid(vga_valid),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_rdata(cpu_rdata), .cpu_ack(cpu_ack),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_rdata(mem_rdata),
        .cpu_starve(cpu_starve)
    );

    // RAM: preloaded during reset, read data one cycle after the address
    always @(posedge clk) begin
        if (reset)
            ram[16'h3000] <= 16'h4142;
        else if (mem_we)
            ram[mem_addr] <= mem_wdata;
        mem_rdata <= ram[mem_addr];
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, ".mem_addr"},   32'(mem_addr),   32'h0);
        chk({tag, ".mem_wdata"},  32'(mem_wdata),  32'h0);
        chk({tag, ".mem_we"},     32'(mem_we),     32'h0);
        chk({tag, ".vga_data"},   32'(vga_data),   32'h0);
        chk({tag, ".vga_valid"},  32'(vga_valid),  32'h0);
        chk({tag, ".cpu_rdata"},  32'(cpu_rdata),  32'h0);
        chk({tag, ".cpu_ack"},    32'(cpu_ack),    32'h0);
        chk({tag, ".cpu_starve"}, 32'(cpu_starve), 32'h0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        reset = 1'b1; vga_req = 1'b0; vga_addr = '0;
        cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
        tick; tick;
        chk_all_zero("reset");
        reset = 1'b0;
        tick;
        chk_all_zero("idle");

        // VGA read of 0x3000: valid after the third edge
        vga_req = 1'b1; vga_addr = 16'h3000;
        tick;
        chk("vga.addr", 32'(mem_addr), 32'h3000);
        chk("vga.we0", 32'(mem_we), 32'h0);
        chk("vga.valid_e1", 32'(vga_valid), 32'h0);
        tick;
        chk("vga.valid_e2", 32'(vga_valid), 32'h0);
        chk("vga.we1", 32'(mem_we), 32'h0);
        tick;
        chk("vga.valid_e3", 32'(vga_valid), 32'h1);
        chk("vga.data", 32'(vga_data), 32'h4142);
        vga_req = 1'b0;
        tick;
        chk("vga.valid_pulse", 32'(vga_valid), 32'h0);

        // CPU write 0xBEEF to 0x0100: ack after 2 edges
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 16'h0100; cpu_wdata = 16'hBEEF;
        tick;
        chk("wr.we", 32'(mem_we), 32'h1);
        chk("wr.addr", 32'(mem_addr), 32'h0100);
        chk("wr.wdata", 32'(mem_wdata), 32'hBEEF);
        chk("wr.ack_e1", 32'(cpu_ack), 32'h0);
        tick;
        chk("wr.ack_e2", 32'(cpu_ack), 32'h1);
        chk("wr.we_drop", 32'(mem_we), 32'h0);
        chk("wr.rdata_keep", 32'(cpu_rdata), 32'h0);
        cpu_req = 1'b0;
        tick;
        chk("wr.ack_pulse", 32'(cpu_ack), 32'h0);

        // CPU read back 0x0100: ack after 3 edges
        cpu_req = 1'b1; cpu_we = 1'b0;
        tick;
        chk("rd.we", 32'(mem_we), 32'h0);
        tick;
        chk("rd.ack_e2", 32'(cpu_ack), 32'h0);
        tick;
        chk("rd.ack_e3", 32'(cpu_ack), 32'h1);
        chk("rd.data", 32'(cpu_rdata), 32'hBEEF);
        cpu_req = 1'b0;
        tick;
        chk("rd.ack_pulse", 32'(cpu_ack), 32'h0);

        // Simultaneous: VGA first, CPU read ack 4 edges after vga_valid
        vga_req = 1'b1; vga_addr = 16'h3000;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h0100;
        tick;
        chk("sim.vga_addr", 32'(mem_addr), 32'h3000);
        tick; tick;
        chk("sim.vga_valid", 32'(vga_valid), 32'h1);
        chk("sim.vga_data", 32'(vga_data), 32'h4142);
        chk("sim.cpu_wait", 32'(cpu_ack), 32'h0);
        vga_req = 1'b0;
        tick;
        chk("sim.no_regrant", 32'(mem_addr), 32'h3000);
        tick;
        chk("sim.cpu_addr", 32'(mem_addr), 32'h0100);
        tick;
        chk("sim.ack_e3", 32'(cpu_ack), 32'h0);
        tick;
        chk("sim.ack_e4", 32'(cpu_ack), 32'h1);
        chk("sim.rdata", 32'(cpu_rdata), 32'hBEEF);
        cpu_req = 1'b0;
        tick;

        // Starvation: VGA hogs the RAM for 40 cycles while the CPU waits
        vga_req = 1'b1; vga_addr = 16'h3000;
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 16'h0200; cpu_wdata = 16'h1234;
        for (int i = 1; i <= 40; i++) begin
            tick;
            chk($sformatf("starve.flag%0d", i), 32'(cpu_starve), (i >= 8) ? 32'h1 : 32'h0);
            chk($sformatf("starve.valid%0d", i), 32'(vga_valid), (i % 4 == 3) ? 32'h1 : 32'h0);
            chk($sformatf("starve.noack%0d", i), 32'(cpu_ack), 32'h0);
        end
        vga_req = 1'b0;
        tick;
        chk("starve.grant_we", 32'(mem_we), 32'h1);
        chk("starve.grant_addr", 32'(mem_addr), 32'h0200);
        chk("starve.cleared", 32'(cpu_starve), 32'h0);
        tick;
        chk("starve.ack", 32'(cpu_ack), 32'h1);
        chk("starve.still_clear", 32'(cpu_starve), 32'h0);
        cpu_req = 1'b0;
        tick;

        // Reset during CPU_WR: no ack, mem_we low, everything cleared
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 16'h0300; cpu_wdata = 16'h5555;
        tick;
        chk("rst.in_write", 32'(mem_we), 32'h1);
        reset = 1'b1;
        tick;
        chk_all_zero("rst.mid");
        reset = 1'b0; cpu_req = 1'b0;
        tick;
        chk("rst.no_ack", 32'(cpu_ack), 32'h0);
        chk("rst.we_low", 32'(mem_we), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
